// File: rtl/if_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, drives a handshaked instruction
// memory and holds up to two returned instructions for the decode stage.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        busy_drop
);
    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DROP} state_t;

    state_t      r_state, w_state_next;
    logic [1:0]  r_count, w_count_next, w_fill;
    logic [31:0] r_inst0, r_pc0, r_inst1, r_pc1, r_fpc, r_addr;
    logic [31:0] w_inst0_next, w_pc0_next, w_inst1_next, w_pc1_next, w_fpc_next, w_addr_next;
    logic [31:0] w_target;
    logic        w_req, w_redirect, w_pop, w_push;

    assign w_req      = ((r_state == S_FETCH) && (r_count != 2'd2)) || (r_state == S_DROP);
    assign w_redirect = (pcsource != 2'b00);
    assign w_pop      = (r_count != 2'd0) && !stall && !w_redirect;
    assign w_push     = (r_state == S_FETCH) && w_req && imem_ready && !w_redirect;
    assign w_fill     = r_count - {1'b0, w_pop};

    always_comb begin
        case (pcsource)
            2'b01:   w_target = bpc;
            2'b10:   w_target = jpc;
            2'b11:   w_target = EXC_VEC;
            default: w_target = r_fpc;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_fpc_next   = r_fpc;
        w_addr_next  = r_addr;
        case (r_state)
            S_BOOT: begin
                w_state_next = S_FETCH;
                w_fpc_next   = w_redirect ? w_target : r_fpc;
                w_addr_next  = w_fpc_next;
            end
            S_FETCH: begin
                if (w_redirect) begin
                    w_fpc_next = w_target;
                    // A request still outstanding must complete before the new target goes out.
                    if (w_req && !imem_ready) w_state_next = S_DROP;
                    else                      w_addr_next  = w_target;
                end else if (w_push) begin
                    w_fpc_next  = r_addr + 32'd4;
                    w_addr_next = r_addr + 32'd4;
                end
            end
            S_DROP: begin
                if (w_redirect) w_fpc_next = w_target;
                if (imem_ready) begin
                    w_state_next = S_FETCH;
                    w_addr_next  = w_fpc_next;
                end
            end
            default: w_state_next = S_BOOT;
        endcase
    end

    always_comb begin
        w_inst0_next = r_inst0;
        w_pc0_next   = r_pc0;
        w_inst1_next = r_inst1;
        w_pc1_next   = r_pc1;
        w_count_next = w_fill + {1'b0, w_push};
        if (w_pop) begin
            w_inst0_next = r_inst1;
            w_pc0_next   = r_pc1;
        end
        // The pop is applied first, so the push lands in the slot it frees.
        if (w_push) begin
            if (w_fill == 2'd0) begin
                w_inst0_next = imem_rdata;
                w_pc0_next   = r_addr;
            end else begin
                w_inst1_next = imem_rdata;
                w_pc1_next   = r_addr;
            end
        end
        if (w_redirect) w_count_next = 2'd0;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_BOOT;
            r_count <= 2'd0;
            r_inst0 <= 32'd0;
            r_pc0   <= 32'd0;
            r_inst1 <= 32'd0;
            r_pc1   <= 32'd0;
            r_fpc   <= RESET_PC;
            r_addr  <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_inst0 <= w_inst0_next;
            r_pc0   <= w_pc0_next;
            r_inst1 <= w_inst1_next;
            r_pc1   <= w_pc1_next;
            r_fpc   <= w_fpc_next;
            r_addr  <= w_addr_next;
        end
    end

    assign imem_req   = w_req;
    assign imem_addr  = r_addr;
    assign inst_valid = (r_count != 2'd0);
    assign inst       = r_inst0;
    assign pc         = r_pc0;
    assign pc4        = r_pc0 + 32'd4;
    assign busy_drop  = (r_state == S_DROP);
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: a fixed vector table, hand sequences for reset/wrap/latency,
// then randomized traffic checked against a queue-based reference model.
module tb_if_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] EXC    = 32'h0000_0180;

    logic        clk = 1'b0, clrn = 1'b0, stall = 1'b0, imem_ready = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'd0, jpc = 32'd0, imem_rdata = 32'd0;
    logic        imem_req, inst_valid, busy_drop;
    logic [31:0] imem_addr, inst, pc, pc4;

    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl #(.RESET_PC(RST_PC), .EXC_VEC(EXC)) dut (
        .clk(clk), .clrn(clrn), .stall(stall), .pcsource(pcsource), .bpc(bpc), .jpc(jpc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst), .pc(pc), .pc4(pc4),
        .busy_drop(busy_drop)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // Reference model: buffer as a queue, plus boot/drop flags and the two addresses.
    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
    ent_t        m_q[$];
    bit          m_boot, m_drop;
    logic [31:0] m_fpc, m_addr;

    function automatic bit m_req();
        return m_drop || (!m_boot && (m_q.size() < 2));
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_boot = 1'b1;
        m_drop = 1'b0;
        m_fpc  = RST_PC;
        m_addr = RST_PC;
    endtask

    task automatic model_step(input bit st, input logic [1:0] ps, input logic [31:0] b,
                              input logic [31:0] j, input bit rdy, input logic [31:0] rd);
        bit          req;
        logic [31:0] tgt;
        req = m_req();
        tgt = (ps == 2'd1) ? b : (ps == 2'd2) ? j : EXC;
        if (ps != 2'd0) begin
            m_q.delete();
            m_fpc = tgt;
            if (m_boot) begin
                m_boot = 1'b0;
                m_addr = tgt;
            end else if (m_drop) begin
                if (rdy) begin m_drop = 1'b0; m_addr = tgt; end
            end else if (req && !rdy) begin
                m_drop = 1'b1;
            end else begin
                m_addr = tgt;
            end
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_addr = m_fpc;
        end else if (m_drop) begin
            if (rdy) begin m_drop = 1'b0; m_addr = m_fpc; end
        end else begin
            if (m_q.size() > 0 && !st) m_q.delete(0);
            if (req && rdy) begin
                m_q.push_back('{inst: rd, pc: m_addr});
                m_addr = m_addr + 32'd4;
                m_fpc  = m_addr;
            end
        end
    endtask

    task automatic check_model(input string tag);
        bit          ev, bad;
        logic [31:0] ep, ei;
        ev  = (m_q.size() > 0);
        ep  = ev ? m_q[0].pc : 32'd0;
        ei  = ev ? m_q[0].inst : 32'd0;
        bad = (imem_req !== m_req()) || (imem_addr !== m_addr) || (inst_valid !== ev) ||
              (busy_drop !== m_drop);
        if (ev && ((pc !== ep) || (inst !== ei) || (pc4 !== ep + 32'd4))) bad = 1'b1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s: got req=%b addr=%h v=%b pc=%h inst=%h pc4=%h drop=%b, want req=%b addr=%h v=%b pc=%h inst=%h drop=%b",
                     tag, imem_req, imem_addr, inst_valid, pc, inst, pc4, busy_drop,
                     m_req(), m_addr, ev, ep, ei, m_drop);
        end
    endtask

    // Memory-side protocol: a request not accepted must reappear unchanged.
    bit          hold_armed = 1'b0;
    logic [31:0] hold_addr  = 32'd0;

    task automatic check_hold();
        if (hold_armed) begin
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== hold_addr) begin
                miscompares++;
                $display("FAIL addr_hold: got req=%b addr=%h, want req=1 addr=%h",
                         imem_req, imem_addr, hold_addr);
            end
        end
    endtask

    task automatic cycle(input bit st, input logic [1:0] ps, input logic [31:0] b,
                         input logic [31:0] j, input bit rdy, input string tag);
        stall      = st;
        pcsource   = ps;
        bpc        = b;
        jpc        = j;
        imem_ready = rdy;
        imem_rdata = mem_word(m_addr);
        hold_armed = (imem_req === 1'b1) && !rdy;
        hold_addr  = imem_addr;
        model_step(st, ps, b, j, rdy, imem_rdata);
        @(posedge clk);
        @(negedge clk);
        check_hold();
        check_model(tag);
    endtask

    int mem_w = 0, mem_lat = 0;

    function automatic bit mem_ready();
        if (!m_req()) return 1'($urandom_range(0, 1));
        return (mem_w >= mem_lat);
    endfunction

    task automatic mem_advance(input bit rdy, input bit rand_lat);
        if (m_req()) begin
            if (rdy) begin
                mem_w = 0;
                if (rand_lat) mem_lat = $urandom_range(0, 3);
            end else begin
                mem_w++;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC || inst_valid !== 1'b0 || inst !== 32'd0 ||
            pc !== 32'd0 || pc4 !== 32'd4 || busy_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got req=%b addr=%h v=%b inst=%h pc=%h pc4=%h drop=%b, want 0 %h 0 0 0 4 0",
                     tag, imem_req, imem_addr, inst_valid, inst, pc, pc4, busy_drop, RST_PC);
        end
    endtask

    typedef struct {
        bit st; logic [1:0] ps; logic [31:0] b; bit rdy;
        bit e_req; logic [31:0] e_addr; bit e_v; logic [31:0] e_pc; bit e_drop;
    } row_t;

    function automatic row_t mk(input bit st, input logic [1:0] ps, input logic [31:0] b,
                                input bit rdy, input bit er, input logic [31:0] ea,
                                input bit ev, input logic [31:0] ep, input bit ed);
        row_t r;
        r.st = st; r.ps = ps; r.b = b; r.rdy = rdy;
        r.e_req = er; r.e_addr = ea; r.e_v = ev; r.e_pc = ep; r.e_drop = ed;
        return r;
    endfunction

    row_t tbl[17];
    int   valid_cnt;
    bit   rdy;
    bit          rst_st;
    logic [1:0]  rst_ps;
    logic [31:0] rst_b, rst_j;

    initial begin
        // Each row: outputs expected now, then inputs applied for the next edge.
        tbl[0]  = mk(1'b0, 2'd0, 32'h00, 1'b1, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0);
        tbl[1]  = mk(1'b0, 2'd0, 32'h00, 1'b1, 1'b1, 32'h000, 1'b0, 32'h000, 1'b0);
        tbl[2]  = mk(1'b0, 2'd0, 32'h00, 1'b1, 1'b1, 32'h004, 1'b1, 32'h000, 1'b0);
        tbl[3]  = mk(1'b1, 2'd0, 32'h00, 1'b1, 1'b1, 32'h008, 1'b1, 32'h004, 1'b0);
        tbl[4]  = mk(1'b1, 2'd0, 32'h00, 1'b1, 1'b0, 32'h00C, 1'b1, 32'h004, 1'b0);
        tbl[5]  = mk(1'b1, 2'd0, 32'h00, 1'b1, 1'b0, 32'h00C, 1'b1, 32'h004, 1'b0);
        tbl[6]  = mk(1'b1, 2'd0, 32'h00, 1'b1, 1'b0, 32'h00C, 1'b1, 32'h004, 1'b0);
        tbl[7]  = mk(1'b0, 2'd0, 32'h00, 1'b1, 1'b0, 32'h00C, 1'b1, 32'h004, 1'b0);
        tbl[8]  = mk(1'b0, 2'd0, 32'h00, 1'b1, 1'b1, 32'h00C, 1'b1, 32'h008, 1'b0);
        tbl[9]  = mk(1'b0, 2'd1, 32'h40, 1'b0, 1'b1, 32'h010, 1'b1, 32'h00C, 1'b0);
        tbl[10] = mk(1'b0, 2'd0, 32'h00, 1'b0, 1'b1, 32'h010, 1'b0, 32'h000, 1'b1);
        tbl[11] = mk(1'b0, 2'd0, 32'h00, 1'b1, 1'b1, 32'h010, 1'b0, 32'h000, 1'b1);
        tbl[12] = mk(1'b0, 2'd0, 32'h00, 1'b1, 1'b1, 32'h040, 1'b0, 32'h000, 1'b0);
        tbl[13] = mk(1'b1, 2'd0, 32'h00, 1'b1, 1'b1, 32'h044, 1'b1, 32'h040, 1'b0);
        tbl[14] = mk(1'b1, 2'd3, 32'h00, 1'b1, 1'b0, 32'h048, 1'b1, 32'h040, 1'b0);
        tbl[15] = mk(1'b0, 2'd0, 32'h00, 1'b1, 1'b1, EXC,      1'b0, 32'h000, 1'b0);
        tbl[16] = mk(1'b0, 2'd0, 32'h00, 1'b0, 1'b1, EXC + 4,  1'b1, EXC,      1'b0);

        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        clrn = 1'b1;

        for (int i = 0; i < 17; i++) begin
            vectors++;
            if (imem_req !== tbl[i].e_req || imem_addr !== tbl[i].e_addr ||
                inst_valid !== tbl[i].e_v || busy_drop !== tbl[i].e_drop ||
                (tbl[i].e_v && (pc !== tbl[i].e_pc || inst !== mem_word(tbl[i].e_pc)))) begin
                miscompares++;
                $display("FAIL table[%0d]: got req=%b addr=%h v=%b pc=%h inst=%h drop=%b, want req=%b addr=%h v=%b pc=%h inst=%h drop=%b",
                         i, imem_req, imem_addr, inst_valid, pc, inst, busy_drop, tbl[i].e_req,
                         tbl[i].e_addr, tbl[i].e_v, tbl[i].e_pc, mem_word(tbl[i].e_pc), tbl[i].e_drop);
            end
            cycle(tbl[i].st, tbl[i].ps, tbl[i].b, 32'd0, tbl[i].rdy, $sformatf("table_model[%0d]", i));
        end

        // Enter DROP, then pull reset mid-cycle: outputs must clear without a clock edge.
        cycle(1'b0, 2'd2, 32'd0, 32'hFFFF_FFFC, 1'b0, "enter_drop");
        #2 clrn = 1'b0;
        #1 check_reset_outputs("async_reset_in_drop");
        model_reset();
        hold_armed = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        check_model("boot_after_reset");
        cycle(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, "first_req_reset_pc");

        // Redirect to the top word of the address space and let the PC wrap.
        cycle(1'b0, 2'd2, 32'd0, 32'hFFFF_FFFC, 1'b1, "redirect_top");
        cycle(1'b1, 2'd0, 32'd0, 32'd0, 1'b1, "capture_top");
        vectors++;
        if (pc !== 32'hFFFF_FFFC || pc4 !== 32'd0 || imem_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL wrap: got pc=%h pc4=%h addr=%h, want fffffffc 00000000 00000000",
                     pc, pc4, imem_addr);
        end

        // Fixed 3-cycle latency, no stall: one instruction every third cycle.
        mem_w = 0;
        mem_lat = 2;
        for (int i = 0; i < 12; i++) begin
            rdy = mem_ready();
            mem_advance(rdy, 1'b0);
            cycle(1'b0, 2'd0, 32'd0, 32'd0, rdy, "lat3_warmup");
        end
        valid_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            rdy = mem_ready();
            mem_advance(rdy, 1'b0);
            cycle(1'b0, 2'd0, 32'd0, 32'd0, rdy, "lat3");
            if (inst_valid === 1'b1) valid_cnt++;
        end
        vectors++;
        if (valid_cnt != 10) begin
            miscompares++;
            $display("FAIL lat3_rate: got %0d valid cycles in 30, want 10", valid_cnt);
        end

        // Randomized traffic with variable latency, stalls, redirects and mid-run resets.
        mem_w = 0;
        mem_lat = $urandom_range(0, 3);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                // Inputs are randomized during reset as well; the model must ignore them.
                rst_st = 1'($urandom_range(0, 1));
                rst_ps = 2'($urandom_range(0, 3));
                rst_b  = $urandom & 32'hFFFF_FFFC;
                rst_j  = $urandom & 32'hFFFF_FFFC;
                stall = rst_st; pcsource = rst_ps; bpc = rst_b; jpc = rst_j;
                clrn = 1'b0;
                #1 check_reset_outputs("rand_reset");
                model_reset();
                hold_armed = 1'b0;
                mem_w = 0;
                @(negedge clk);
                clrn = 1'b1;
            end else begin
                logic [1:0]  ps;
                logic [31:0] b, j;
                bit          st;
                st = ($urandom_range(0, 2) == 0);
                ps = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                b  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
                j  = $urandom & 32'hFFFF_FFFC;
                rdy = mem_ready();
                mem_advance(rdy, 1'b1);
                cycle(st, ps, b, j, rdy, "random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Fetch sequencer between the pipeline front end and a handshaked instruction memory with variable latency.
- Owns the fetch PC and issues req/addr to memory.
- Buffers up to two returned instructions so a 0-wait memory sustains one instruction per cycle under ID stalls.
- Applies branch/jump/vector redirects from ID, including discarding a stale in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
EXC_VEC, 32'h0000_0000, target for pcsource=2'b11

Ports:
clk  in  1  clock, rising edge
clrn  in  1  asynchronous active-low reset
stall  in  1  ID not accepting; head instruction held
pcsource  in  2  00 sequential, 01 bpc, 10 jpc, 11 EXC_VEC
bpc  in  32  branch target
jpc  in  32  jump target
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_ready  in  1  read data valid this cycle (meaningful only while imem_req=1)
imem_rdata  in  32  instruction word
inst_valid  out  1  head entry valid
inst  out  32  head instruction
pc  out  32  address of head instruction
pc4  out  32  pc+4
busy_drop  out  1  stale fetch being discarded

Behaviour:
- Reset (clrn=0, async) forces:
  - state=BOOT, count=0, inst_valid=0, inst=0, pc=0, pc4=4, imem_req=0, busy_drop=0.
  - Fetch PC (fpc)=RESET_PC, imem_addr=RESET_PC.
- States:
  - BOOT: one cycle with no request, then FETCH.
  - FETCH: issues requests while the buffer has room.
  - DROP: waits for an abandoned request to complete.
- Buffer: 2 entries {inst, pc}; head=entry0 drives inst/pc; count 0..2; inst_valid=(count!=0).
- imem_req=1 in FETCH when count<2; imem_req=1 always in DROP; otherwise 0.
- imem_addr is registered; it changes only on the edge where imem_ready=1 was sampled, or on leaving BOOT/DROP.
- Memory rule: once raised, req and addr stay stable until the edge sampling imem_ready=1.
- Consume: inst_valid & ~stall & pcsource==00 at an edge pops the head; entry1 shifts to entry0.
- Capture in FETCH with imem_ready=1 and no redirect:
  - Push {imem_rdata, imem_addr} at the tail; a same-cycle pop applies first.
  - fpc<=imem_addr+4; the next request is issued the following cycle with no bubble.
- count update: +1 on capture, -1 on pop, unchanged on both; it never exceeds 2.
- count==2: req low; fpc holds until a pop.
- Redirect (pcsource!=00):
  - Has priority over stall and capture; no delay slot.
  - All entries are flushed at the edge (count=0, inst_valid=0); fpc<=target.
  - If req=1 and imem_ready=0 that cycle: go to DROP, with addr held at the old value.
  - Otherwise (ready=1 or no request): stay in/enter FETCH with addr=target next cycle; any returning data is discarded.
- DROP:
  - busy_drop=1.
  - On imem_ready=1, data is discarded and the state goes to FETCH with addr=fpc.
  - A redirect in DROP updates fpc only.
  - A redirect in BOOT sets fpc; BOOT still lasts one cycle.
- Widths: all PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- pc4 = pc+4, combinational from the head pc.

Test Plan:
- Reset, then ready tied 1, stall 0: req rises on cycle 2; inst_valid from cycle 3; pc sequence 0,4,8,C one per cycle; no gaps.
- 0-wait memory, stall held high 4 cycles from the 2nd instruction:
  - count reaches 2; req drops; pc stays 4 during stall.
  - After release, pc steps 4,8,C with no instruction lost or duplicated.
- 3-cycle latency memory:
  - imem_addr stable while req high; inst_valid pulses every 3 cycles.
  - Forcing an addr change mid-request is flagged by an assertion.
- Redirect pcsource=01, bpc=32'h40 while a request to 32'h10 is pending:
  - State enters DROP; busy_drop=1 until ready.
  - Data for 10 is never presented; next pc presented = 40.
- Redirect pcsource=11 on the same edge as imem_ready=1 with count=2 and stall=1:
  - Buffer flushed; count=0.
  - Next request addr=EXC_VEC; captured data discarded.
- Reset asserted mid-DROP: outputs return to reset values immediately (async); after release, first request addr=RESET_PC.
